riscv_nn_apu_resp: RTL and testbench

//  Responder end of the core's APU req/gnt/valid protocol: one shared

---
 rtl/riscv_nn_apu_resp.sv | 198 +++++++++++++++++++
 tb/tb_riscv_nn_apu_resp.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_nn_apu_resp.sv
// APU responder: one shared arithmetic unit with combinational, 2-stage multiply
// and iterative divide classes; results return in grant order, at most 2 in flight.
module riscv_nn_apu_resp #(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             apu_req_i,
  output logic             apu_gnt_o,
  input  logic [2:0]       apu_op_i,
  input  logic [1:0]       apu_lat_i,
  input  logic [1:0][31:0] apu_operands_i,
  output logic             apu_valid_o,
  output logic [31:0]      apu_result_o,
  input  logic             apu_ready_i,
  output logic             busy_o,
  output logic             err_o
);

  localparam int unsigned CntW = $clog2(DIV_ITERS) + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  logic [31:0] op_a, op_b;
  logic [1:0]  op_class;
  logic        pipe_empty, gnt_common;

  // Multiply pipe
  logic        s1_v_q, s1_hi_q, s2_v_q, s2_hi_q, pipe_adv;
  logic [31:0] s1_a_q, s1_b_q;
  logic [63:0] prod, s2_prod_q;

  // Divider
  div_state_e      div_state_q;
  logic [CntW-1:0] div_cnt_q;
  logic [31:0]     rem_q, quot_q, dvsr_q;
  logic            neg_q_q, neg_r_q, is_rem_q, dz_q;
  logic [32:0]     rem_sh;
  logic            rem_ge;
  logic [31:0]     rem_nxt, q_fix, r_fix, div_res;

  logic [31:0] lat1_res;
  logic        hold_v_q;
  logic [31:0] hold_d_q;
  logic        err_q;

  assign op_a = apu_operands_i[0];
  assign op_b = apu_operands_i[1];

  // Class comes from the opcode alone; apu_lat_i is only checked against it.
  assign op_class = !apu_op_i[2] ? 2'd1 : (apu_op_i[1] ? 2'd3 : 2'd2);

  assign pipe_empty = !s1_v_q && !s2_v_q;
  assign gnt_common = apu_req_i && !hold_v_q && apu_ready_i && (div_state_q == StIdle);

  always_comb begin
    apu_gnt_o = 1'b0;
    unique case (op_class)
      2'd1, 2'd3: apu_gnt_o = gnt_common && pipe_empty;
      2'd2:       apu_gnt_o = gnt_common;
      default:    apu_gnt_o = 1'b0;
    endcase
  end

  always_comb begin
    lat1_res = '0;
    unique case (apu_op_i[1:0])
      2'd0: lat1_res = op_a + op_b;
      2'd1: lat1_res = op_a - op_b;
      2'd2: lat1_res = ($signed(op_a) < $signed(op_b)) ? op_a : op_b;
      2'd3: lat1_res = ($signed(op_a) < $signed(op_b)) ? op_b : op_a;
      default: lat1_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // 2-stage multiplier; freezes while stage 2 holds an unaccepted result
  // ---------------------------------------------------------------------------
  assign pipe_adv = !s2_v_q || apu_ready_i;
  assign prod = $signed({{32{s1_a_q[31]}}, s1_a_q}) * $signed({{32{s1_b_q[31]}}, s1_b_q});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q    <= 1'b0;
      s1_hi_q   <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_hi_q   <= 1'b0;
      s2_prod_q <= '0;
    end else if (pipe_adv) begin
      s1_v_q    <= apu_gnt_o && (op_class == 2'd2);
      s1_hi_q   <= apu_op_i[0];
      s1_a_q    <= op_a;
      s1_b_q    <= op_b;
      s2_v_q    <= s1_v_q;
      s2_hi_q   <= s1_hi_q;
      s2_prod_q <= prod;
    end
  end

  // ---------------------------------------------------------------------------
  // Radix-2 restoring divider on magnitudes; signs applied in DONE
  // ---------------------------------------------------------------------------
  assign rem_sh  = {rem_q, quot_q[31]};
  assign rem_ge  = rem_sh >= {1'b0, dvsr_q};
  assign rem_nxt = rem_ge ? 32'(rem_sh - {1'b0, dvsr_q}) : rem_sh[31:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_state_q <= StIdle;
      div_cnt_q   <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      dvsr_q      <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      is_rem_q    <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      unique case (div_state_q)
        StIdle: begin
          if (apu_gnt_o && (op_class == 2'd3)) begin
            div_state_q <= StBusy;
            div_cnt_q   <= '0;
            rem_q       <= '0;
            quot_q      <= op_a[31] ? 32'(-op_a) : op_a;
            dvsr_q      <= op_b[31] ? 32'(-op_b) : op_b;
            neg_q_q     <= op_a[31] ^ op_b[31];
            neg_r_q     <= op_a[31];
            is_rem_q    <= apu_op_i[0];
            dz_q        <= (op_b == '0);
          end
        end
        StBusy: begin
          rem_q     <= rem_nxt;
          quot_q    <= {quot_q[30:0], rem_ge};
          div_cnt_q <= div_cnt_q + 1'b1;
          if (div_cnt_q == CntW'(DIV_ITERS - 1)) div_state_q <= StDone;
        end
        StDone: begin
          if (apu_ready_i) div_state_q <= StIdle;
        end
        default: div_state_q <= StIdle;
      endcase
    end
  end

  assign q_fix   = neg_q_q ? 32'(-quot_q) : quot_q;
  assign r_fix   = neg_r_q ? 32'(-rem_q) : rem_q;
  // Divide by zero naturally leaves the dividend in rem, so only DIV needs an override.
  assign div_res = is_rem_q ? r_fix : (dz_q ? 32'hFFFF_FFFF : q_fix);

  // ---------------------------------------------------------------------------
  // Result selection and hold
  // ---------------------------------------------------------------------------
  always_comb begin
    apu_valid_o  = 1'b0;
    apu_result_o = '0;
    if (hold_v_q) begin
      apu_valid_o  = 1'b1;
      apu_result_o = hold_d_q;
    end else if (s2_v_q) begin
      apu_valid_o  = 1'b1;
      apu_result_o = s2_hi_q ? s2_prod_q[63:32] : s2_prod_q[31:0];
    end else if (div_state_q == StDone) begin
      apu_valid_o  = 1'b1;
      apu_result_o = div_res;
    end else if (apu_gnt_o && (op_class == 2'd1)) begin
      apu_valid_o  = 1'b1;
      apu_result_o = lat1_res;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_v_q <= 1'b0;
      hold_d_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (!hold_v_q && apu_valid_o && !apu_ready_i) begin
        hold_v_q <= 1'b1;
        hold_d_q <= apu_result_o;
      end else if (apu_ready_i) begin
        hold_v_q <= 1'b0;
      end
      if (apu_gnt_o && (apu_lat_i != op_class)) err_q <= 1'b1;
    end
  end

  assign err_o  = err_q;
  assign busy_o = s1_v_q || s2_v_q || (div_state_q != StIdle) || hold_v_q;

  // Grant rules keep the multiplier and divider from presenting results together.
  a_no_collision: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(s2_v_q && (div_state_q == StDone)));

endmodule

// File: tb/tb_riscv_nn_apu_resp.sv
// Directed bench for riscv_nn_apu_resp: one task per scenario, inline checks.
module tb_riscv_nn_apu_resp;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             apu_req_i;
  logic             apu_gnt_o;
  logic [2:0]       apu_op_i;
  logic [1:0]       apu_lat_i;
  logic [1:0][31:0] apu_operands_i;
  logic             apu_valid_o;
  logic [31:0]      apu_result_o;
  logic             apu_ready_i;
  logic             busy_o;
  logic             err_o;

  int passed = 0;
  int total  = 0;

  riscv_nn_apu_resp #(.DIV_ITERS(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .apu_req_i      (apu_req_i),
    .apu_gnt_o      (apu_gnt_o),
    .apu_op_i       (apu_op_i),
    .apu_lat_i      (apu_lat_i),
    .apu_operands_i (apu_operands_i),
    .apu_valid_o    (apu_valid_o),
    .apu_result_o   (apu_result_o),
    .apu_ready_i    (apu_ready_i),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic req, input logic [2:0] op, input logic [1:0] lat,
                       input logic [31:0] a, input logic [31:0] b);
    apu_req_i         = req;
    apu_op_i          = op;
    apu_lat_i         = lat;
    apu_operands_i[0] = a;
    apu_operands_i[1] = b;
  endtask

  task automatic do_reset();
    drive(1'b0, 3'd0, 2'd1, 32'd0, 32'd0);
    apu_ready_i = 1'b1;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // Issues one divider op and waits the fixed latency; returns what the DUT showed.
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic gnt, output int early, output logic vld,
                         output logic [31:0] res);
    next_cycle();
    drive(1'b1, op, 2'd3, a, b);
    @(negedge clk_i);
    gnt = apu_gnt_o;
    early = 0;
    next_cycle();
    drive(1'b0, 3'd0, 2'd1, 32'd0, 32'd0);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_i);
      if (apu_valid_o) early++;
      next_cycle();
    end
    @(negedge clk_i);
    vld = apu_valid_o;
    res = apu_result_o;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i);
    total++; if (apu_valid_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", apu_valid_o); else passed++;
    total++; if (apu_result_o !== 32'd0) $display("FAIL reset_result got %h exp 0", apu_result_o); else passed++;
    total++; if (err_o !== 1'b0) $display("FAIL reset_err got %b exp 0", err_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_o); else passed++;
    total++; if (apu_gnt_o !== 1'b0) $display("FAIL reset_gnt got %b exp 0", apu_gnt_o); else passed++;
  endtask

  task automatic test_lat1();
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] as  [4] = '{32'd5, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'd7, 32'd5, 32'd1, 32'd1};
    logic [31:0] exp [4] = '{32'd12, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1};
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive(1'b1, ops[i], 2'd1, as[i], bs[i]);
      @(negedge clk_i);
      total++;
      if (apu_gnt_o !== 1'b1 || apu_valid_o !== 1'b1 || apu_result_o !== exp[i])
        $display("FAIL lat1_op%0d got gnt=%b valid=%b res=%h exp gnt=1 valid=1 res=%h",
                 i, apu_gnt_o, apu_valid_o, apu_result_o, exp[i]);
      else passed++;
    end
    next_cycle();
    drive(1'b0, 3'd0, 2'd1, 32'd0, 32'd0);
    @(negedge clk_i);
    total++; if (err_o !== 1'b0) $display("FAIL lat1_err got %b exp 0", err_o); else passed++;
  endtask

  task automatic test_back_to_back();
    next_cycle();
    drive(1'b1, 3'd4, 2'd2, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk_i);
    total++; if (apu_gnt_o !== 1'b1 || apu_valid_o !== 1'b0)
      $display("FAIL mul_grant got gnt=%b valid=%b exp gnt=1 valid=0", apu_gnt_o, apu_valid_o);
    else passed++;
    next_cycle();
    drive(1'b1, 3'd5, 2'd2, 32'h8000_0000, 32'd2);
    @(negedge clk_i);
    total++; if (apu_gnt_o !== 1'b1 || apu_valid_o !== 1'b0)
      $display("FAIL mulh_grant got gnt=%b valid=%b exp gnt=1 valid=0", apu_gnt_o, apu_valid_o);
    else passed++;
    next_cycle();
    drive(1'b0, 3'd0, 2'd1, 32'd0, 32'd0);
    @(negedge clk_i);
    total++; if (apu_valid_o !== 1'b1 || apu_result_o !== 32'hFFFF_FFFE)
      $display("FAIL mul_result got valid=%b res=%h exp valid=1 res=fffffffe", apu_valid_o, apu_result_o);
    else passed++;
    next_cycle();
    @(negedge clk_i);
    total++; if (apu_valid_o !== 1'b1 || apu_result_o !== 32'hFFFF_FFFF)
      $display("FAIL mulh_result got valid=%b res=%h exp valid=1 res=ffffffff", apu_valid_o, apu_result_o);
    else passed++;
    next_cycle();
    @(negedge clk_i);
    total++; if (apu_valid_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL mul_drain got valid=%b busy=%b exp 0 0", apu_valid_o, busy_o);
    else passed++;
  endtask

  task automatic test_div();
    logic [2:0]  ops [6] = '{3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7};
    logic [31:0] as  [6] = '{32'd100, 32'd100, 32'd55, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF};
    logic [31:0] exp [6] = '{32'hFFFF_FFF2, 32'd2, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0};
    logic g, v;
    int early;
    logic [31:0] r;
    for (int i = 0; i < 6; i++) begin
      run_div(ops[i], as[i], bs[i], g, early, v, r);
      total++;
      if (g !== 1'b1 || early != 0 || v !== 1'b1 || r !== exp[i])
        $display("FAIL div_case%0d got gnt=%b early=%0d valid=%b res=%h exp gnt=1 early=0 valid=1 res=%h",
                 i, g, early, v, r, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_order();
    int gnt_seen = 0;
    next_cycle();
    drive(1'b1, 3'd6, 2'd3, 32'd50, 32'd5);
    @(negedge clk_i);
    total++; if (apu_gnt_o !== 1'b1) $display("FAIL order_div_gnt got %b exp 1", apu_gnt_o); else passed++;
    next_cycle();
    drive(1'b1, 3'd0, 2'd1, 32'd20, 32'd22);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_i);
      if (apu_gnt_o) gnt_seen++;
      next_cycle();
    end
    @(negedge clk_i);
    total++; if (gnt_seen != 0 || apu_gnt_o !== 1'b0 || apu_valid_o !== 1'b1 || apu_result_o !== 32'd10)
      $display("FAIL order_div_result got early_gnts=%0d gnt=%b valid=%b res=%h exp 0 0 1 0000000a",
               gnt_seen, apu_gnt_o, apu_valid_o, apu_result_o);
    else passed++;
    next_cycle();
    @(negedge clk_i);
    total++; if (apu_gnt_o !== 1'b1 || apu_valid_o !== 1'b1 || apu_result_o !== 32'd42)
      $display("FAIL order_add got gnt=%b valid=%b res=%h exp 1 1 0000002a",
               apu_gnt_o, apu_valid_o, apu_result_o);
    else passed++;
    next_cycle();
    drive(1'b0, 3'd0, 2'd1, 32'd0, 32'd0);
  endtask

  task automatic test_backpressure();
    int bad = 0;
    next_cycle();
    drive(1'b1, 3'd4, 2'd2, 32'd3, 32'd4);
    @(negedge clk_i);
    total++; if (apu_gnt_o !== 1'b1) $display("FAIL bp_mul_gnt got %b exp 1", apu_gnt_o); else passed++;
    next_cycle();
    drive(1'b0, 3'd0, 2'd1, 32'd0, 32'd0);
    apu_ready_i = 1'b0;
    next_cycle();
    drive(1'b1, 3'd0, 2'd1, 32'd1, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      if (apu_valid_o !== 1'b1 || apu_result_o !== 32'd12 || apu_gnt_o !== 1'b0 || busy_o !== 1'b1)
        bad++;
      next_cycle();
    end
    total++; if (bad != 0) $display("FAIL bp_stall got %0d bad cycles exp 0", bad); else passed++;
    drive(1'b0, 3'd0, 2'd1, 32'd0, 32'd0);
    apu_ready_i = 1'b1;
    @(negedge clk_i);
    total++; if (apu_valid_o !== 1'b1 || apu_result_o !== 32'd12)
      $display("FAIL bp_release got valid=%b res=%h exp 1 0000000c", apu_valid_o, apu_result_o);
    else passed++;
    next_cycle();
    @(negedge clk_i);
    total++; if (apu_valid_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL bp_drain got valid=%b busy=%b exp 0 0", apu_valid_o, busy_o);
    else passed++;
  endtask

  task automatic test_err();
    next_cycle();
    drive(1'b1, 3'd0, 2'd3, 32'd9, 32'd8);
    @(negedge clk_i);
    total++; if (apu_gnt_o !== 1'b1 || apu_valid_o !== 1'b1 || apu_result_o !== 32'd17 || err_o !== 1'b0)
      $display("FAIL err_op got gnt=%b valid=%b res=%h err=%b exp 1 1 00000011 0",
               apu_gnt_o, apu_valid_o, apu_result_o, err_o);
    else passed++;
    next_cycle();
    drive(1'b0, 3'd0, 2'd1, 32'd0, 32'd0);
    repeat (3) next_cycle();
    @(negedge clk_i);
    total++; if (err_o !== 1'b1) $display("FAIL err_sticky got %b exp 1", err_o); else passed++;
    do_reset();
    @(negedge clk_i);
    total++; if (err_o !== 1'b0) $display("FAIL err_cleared got %b exp 0", err_o); else passed++;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    next_cycle();
    drive(1'b1, 3'd6, 2'd3, 32'd77, 32'd7);
    next_cycle();
    drive(1'b0, 3'd0, 2'd1, 32'd0, 32'd0);
    repeat (5) next_cycle();
    do_reset();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (apu_valid_o || busy_o) seen++;
      next_cycle();
    end
    total++; if (seen != 0) $display("FAIL reset_mid got %0d active cycles exp 0", seen); else passed++;
  endtask

  initial begin
    test_reset();
    test_lat1();
    test_back_to_back();
    test_div();
    test_order();
    test_backpressure();
    test_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
